// File: rtl/multi_receive_switch.sv
// Per-channel T/R receive-switch controller: blank on GEN, re-arm DELAY after MA falls.
// Define RSW_INPUT_SYNC_EN to put a 2-FF synchronizer on GEN/MA (+2 cycles latency).
module multi_receive_switch #(
  parameter int          NCH     = 4,
  parameter int          CNT_W   = 16,
  parameter int          TIMEOUT = 20000,
  parameter logic        ON      = 1'b0,
  parameter logic        OFF     = 1'b1
) (
  input  logic             CLOCK_10M,
  input  logic             RST_N,
  input  logic             SW_EN,
  input  logic [7:0]       PROBE_MODE,
  input  logic [NCH-1:0]   GEN,
  input  logic [NCH-1:0]   MA,
  input  logic [CNT_W-1:0] DELAY,
  input  logic             FAULT_CLR,
  output logic [NCH-1:0]   RECEIVE_SW,
  output logic [NCH-1:0]   FAULT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LISTEN,
    S_BLANK,
    S_RECOVER
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NCH-1:0] tr;
  logic           run;
  logic           fixed_on;

  assign run      = SW_EN && (PROBE_MODE == 8'd1);
  assign fixed_on = (PROBE_MODE == 8'd3) || (PROBE_MODE == 8'd4);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dly;
    logic             tr_q;
    logic             flt_q;
    logic [1:0]       gen_sr;
    logic [1:0]       ma_sr;
    logic             gen_smp;
    logic             ma_smp;
    logic             gen_rise;
    logic             ma_fall;
    logic             tmo_hit;

`ifdef RSW_INPUT_SYNC_EN
    logic [1:0] gen_sy;
    logic [1:0] ma_sy;

    always_ff @(posedge CLOCK_10M) begin
      if (!RST_N) begin
        gen_sy <= '0;
        ma_sy  <= '0;
      end else begin
        gen_sy <= {gen_sy[0], GEN[i]};
        ma_sy  <= {ma_sy[0], MA[i]};
      end
    end

    assign gen_smp = gen_sy[1];
    assign ma_smp  = ma_sy[1];
`else
    assign gen_smp = GEN[i];
    assign ma_smp  = MA[i];
`endif

    assign gen_rise = (gen_sr == 2'b01);
    assign ma_fall  = (ma_sr == 2'b10);

    // Timeout only counts when no higher-priority event is pending
    assign tmo_hit = run && (st == S_BLANK) && !gen_rise
                  && !ma_fall && (cnt == TMO_LAST);

    always_ff @(posedge CLOCK_10M) begin
      if (!RST_N) begin
        st     <= S_IDLE;
        cnt    <= '0;
        dly    <= '0;
        tr_q   <= OFF;
        flt_q  <= 1'b0;
        gen_sr <= '0;
        ma_sr  <= '0;
      end else begin
        gen_sr <= {gen_sr[0], gen_smp};
        ma_sr  <= {ma_sr[0], ma_smp};

        if (tmo_hit)
          flt_q <= 1'b1;
        else if (FAULT_CLR)
          flt_q <= 1'b0;

        if (!run) begin
          st   <= S_IDLE;
          cnt  <= '0;
          tr_q <= (SW_EN && fixed_on) ? ON : OFF;
        end else begin
          unique case (st)
            S_IDLE: begin
              st   <= S_RECOVER;
              tr_q <= OFF;
              cnt  <= '0;
              dly  <= DELAY;
            end
            S_LISTEN: begin
              if (gen_rise) begin
                st   <= S_BLANK;
                tr_q <= OFF;
                cnt  <= '0;
              end else begin
                tr_q <= ON;
              end
            end
            S_BLANK: begin
              tr_q <= OFF;
              if (gen_rise) begin
                cnt <= '0;
              end else if (ma_fall || tmo_hit) begin
                st  <= S_RECOVER;
                cnt <= '0;
                dly <= DELAY;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
            S_RECOVER: begin
              if (gen_rise) begin
                st   <= S_BLANK;
                tr_q <= OFF;
                cnt  <= '0;
              end else if (cnt == dly) begin
                st   <= S_LISTEN;
                tr_q <= ON;
              end else begin
                tr_q <= OFF;
                cnt  <= cnt + CNT_ONE;
              end
            end
            default: begin
              st   <= S_IDLE;
              tr_q <= OFF;
              cnt  <= '0;
            end
          endcase
        end
      end
    end

    assign tr[i]    = tr_q;
    assign FAULT[i] = flt_q;
  end

  assign RECEIVE_SW = SW_EN ? tr : {NCH{OFF}};

endmodule
